// File: rtl/mmio_pkg.sv
// Shared word-index map and window geometry for the MMIO port bank.
package mmio_pkg;
  localparam int WINDOW_BITS    = 6;
  localparam int IDX_W          = 4;
  localparam int IN_BASE_IDX    = 0;
  localparam int OUT_BASE_IDX   = 8;
  localparam int STATUS_IDX     = 15;
  localparam int STATUS_OVF_LSB = 8;
endpackage

// File: rtl/mmio_debounce.sv
// Two-flop synchroniser plus stable-count debouncer; rise is combinational and marks the edge
// on which level goes high, so the consumer captures on that same edge. No backpressure.
module mmio_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ;
  logic             flip;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    differ  = (sync2_q != level_q);
    // The cycle that would bring the count to DEBOUNCE_CYCLES flips the level instead.
    flip    = differ && (cnt_q == CNT_LAST);
    level_d = level_q;
    cnt_d   = '0;
    if (flip) begin
      level_d = ~level_q;
    end else if (differ) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = flip && !level_q;
endmodule

// File: rtl/mmio_port_bank.sv
// 64-byte MMIO window: debounced input capture, CPU output registers, sticky status; 1-cycle
// registered reads, writes land on the request edge; no backpressure, every hit is accepted.
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int                WIDTH           = 32,
  parameter int                ADDR_W          = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'hFFC0,
  parameter int                NUM_IN          = 2,
  parameter int                IN_WIDTH        = 10,
  parameter int                NUM_OUT         = 1,
  parameter int                DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       hit,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic [NUM_IN*IN_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]          in_load,
  output logic [NUM_OUT*WIDTH-1:0]   out_ports
);
  logic [IDX_W-1:0]    idx;
  logic                rd_acc, wr_acc;
  logic [NUM_IN-1:0]   rise, dbn_level;
  logic [WIDTH-1:0]    rd_mux;

  logic [IN_WIDTH-1:0] in_reg_q  [NUM_IN];
  logic [IN_WIDTH-1:0] in_reg_d  [NUM_IN];
  logic [WIDTH-1:0]    out_reg_q [NUM_OUT];
  logic [WIDTH-1:0]    out_reg_d [NUM_OUT];
  logic [NUM_IN-1:0]   new_flag_q, new_flag_d;
  logic [NUM_IN-1:0]   ovf_flag_q, ovf_flag_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic unused_sig;
  assign unused_sig = ^{addr[1:0], dbn_level};

  assign hit    = (addr[ADDR_W-1:WINDOW_BITS] == BASE_ADDR[ADDR_W-1:WINDOW_BITS]);
  assign idx    = addr[WINDOW_BITS-1:2];
  assign rd_acc = rd_en && hit;
  assign wr_acc = wr_en && hit;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn (
      .clk   (clk),
      .rst   (rst),
      .raw   (in_load[g]),
      .level (dbn_level[g]),
      .rise  (rise[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_ports[g*WIDTH +: WIDTH] = out_reg_q[g];
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx == IDX_W'(IN_BASE_IDX + i)) rd_mux = WIDTH'(in_reg_q[i]);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (idx == IDX_W'(OUT_BASE_IDX + j)) rd_mux = out_reg_q[j];
    end
    if (idx == IDX_W'(STATUS_IDX)) begin
      rd_mux[NUM_IN-1:0]                = new_flag_q;
      rd_mux[STATUS_OVF_LSB +: NUM_IN]  = ovf_flag_q;
    end
  end

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? rd_mux : rd_data_q;
    new_flag_d = new_flag_q;
    ovf_flag_d = ovf_flag_q;
    if (rd_acc && idx == IDX_W'(STATUS_IDX)) ovf_flag_d = '0;
    // Clears are applied first so a capture on the same edge overrides them.
    for (int i = 0; i < NUM_IN; i++) begin
      in_reg_d[i] = in_reg_q[i];
      if (rd_acc && idx == IDX_W'(IN_BASE_IDX + i)) new_flag_d[i] = 1'b0;
      if (rise[i]) begin
        in_reg_d[i]   = in_data[i*IN_WIDTH +: IN_WIDTH];
        new_flag_d[i] = 1'b1;
        if (new_flag_q[i]) ovf_flag_d[i] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      out_reg_d[j] = out_reg_q[j];
      if (wr_acc && idx == IDX_W'(OUT_BASE_IDX + j)) out_reg_d[j] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++)  in_reg_q[i]  <= '0;
      for (int j = 0; j < NUM_OUT; j++) out_reg_q[j] <= '0;
      new_flag_q <= '0;
      ovf_flag_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)  in_reg_q[i]  <= in_reg_d[i];
      for (int j = 0; j < NUM_OUT; j++) out_reg_q[j] <= out_reg_d[j];
      new_flag_q <= new_flag_d;
      ovf_flag_q <= ovf_flag_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank at default parameters; expected values hand-derived.
module tb_mmio_port_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wr_data;
  logic        hit;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [19:0] in_data;
  logic [1:0]  in_load;
  logic [31:0] out_ports;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_port_bank dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .hit       (hit),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .in_data   (in_data),
    .in_load   (in_load),
    .out_ports (out_ports)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'b0, rd_valid}, 32'h1);
    check({tag, "_data"}, rd_data, exp);
    tick();
    check({tag, "_valid_drop"}, {31'b0, rd_valid}, 32'h0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic press(input int ch, input logic [9:0] d);
    in_data[ch*10 +: 10] = d;
    in_load[ch] = 1'b1;
    repeat (8) tick();
    in_load[ch] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    // Reset with junk on every input
    rst = 1'b1; addr = 16'hFFE0; rd_en = 1'b1; wr_en = 1'b1;
    wr_data = 32'h1234_5678; in_data = 20'hFFFFF; in_load = 2'b11;
    repeat (3) tick();
    check("rst_out_ports", out_ports, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    rd_en = 1'b0; wr_en = 1'b0; in_load = 2'b00; in_data = '0;
    rst = 1'b0;
    tick();
    do_read(16'hFFFC, 32'h0, "rst_status");

    // Capture latency on ch0: update lands on edge 6 after the strobe rises
    in_data[9:0] = 10'h2A5;
    in_load[0] = 1'b1;
    repeat (4) tick();
    addr = 16'hFFC0; rd_en = 1'b1;
    tick();
    check("cap_e5_data", rd_data, 32'h0);
    tick();
    check("cap_e6_data_old", rd_data, 32'h0);
    tick();
    check("cap_e7_data_new", rd_data, 32'h2A5);
    check("cap_e7_valid", {31'b0, rd_valid}, 32'h1);
    rd_en = 1'b0;
    tick();
    check("cap_valid_drop", {31'b0, rd_valid}, 32'h0);
    check("cap_data_hold", rd_data, 32'h2A5);
    in_load[0] = 1'b0;
    repeat (8) tick();
    do_read(16'hFFFC, 32'h0, "cap_status");

    // Glitch: 3-cycle pulse on ch1 is rejected
    in_data[19:10] = 10'h3C3;
    in_load[1] = 1'b1;
    repeat (3) tick();
    in_load[1] = 1'b0;
    repeat (8) tick();
    do_read(16'hFFFC, 32'h0, "glitch_status");
    do_read(16'hFFC4, 32'h0, "glitch_ch1");

    // Overflow: two presses on ch1 without reading
    press(1, 10'h0F0);
    press(1, 10'h155);
    do_read(16'hFFFC, 32'h0000_0202, "ovf_status");
    do_read(16'hFFFC, 32'h0000_0002, "ovf_status_cleared");
    do_read(16'hFFC4, 32'h0000_0155, "ovf_ch1");
    do_read(16'hFFFC, 32'h0, "ovf_status_zero");

    // Output registers
    do_write(16'hFFE0, 32'hDEAD_BEEF);
    check("out_write", out_ports, 32'hDEAD_BEEF);
    addr = 16'hFFE0; wr_data = 32'h1; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_same_old", rd_data, 32'hDEAD_BEEF);
    check("rw_same_out", out_ports, 32'h1);
    do_write(16'hFFC0, 32'h0000_03FF);
    check("wr_in_ignored_out", out_ports, 32'h1);
    do_read(16'hFFC0, 32'h2A5, "wr_in_ignored_ch0");
    do_read(16'hFFE3, 32'h1, "out_readback_lowbits");

    // Miss
    addr = 16'h0040;
    #1;
    check("miss_hit", {31'b0, hit}, 32'h0);
    rd_en = 1'b1;
    wr_en = 1'b1; wr_data = 32'hCAFE_0000;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("miss_valid", {31'b0, rd_valid}, 32'h0);
    check("miss_data_hold", rd_data, 32'h1);
    check("miss_no_write", out_ports, 32'h1);
    addr = 16'hFFC3;
    #1;
    check("hit_window", {31'b0, hit}, 32'h1);
    do_read(16'hFFD0, 32'h0, "unmapped_idx");

    // Collision: read ch0 on the capture edge
    in_data[9:0] = 10'h0AB;
    in_load[0] = 1'b1;
    repeat (5) tick();
    addr = 16'hFFC0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("coll_old_value", rd_data, 32'h2A5);
    check("coll_valid", {31'b0, rd_valid}, 32'h1);
    in_load[0] = 1'b0;
    repeat (8) tick();
    do_read(16'hFFFC, 32'h0000_0001, "coll_flag_kept");
    do_read(16'hFFC0, 32'h0000_00AB, "coll_new_value");
    do_read(16'hFFFC, 32'h0, "coll_status_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
